s3_max_pooling: RTL and testbench

Sequential 2x2/stride-2 max-pooling stage that consumes the 144-entry ReLU'd convolution result of the stage-2 tensor processor: 4 filter channels of 6x6, 35-bit signed. It produces a 4x3x3 pooled tensor, one window per clock. Each window result is saturated and rescaled to the narrower operand width used by the next convolution stage. A start/busy/done handshake lets the top-level controller launch it once stage 2 has filled its result array.

---
 rtl/s3_max_pooling.sv | 120 ++++++++++++
 tb/tb_s3_max_pooling.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/s3_max_pooling.sv
// s3_max_pooling: 2x2/stride-2 max pooling over a 4x6x6 tensor,
// one window per clock, with shift and saturation to OWIDTH.
module s3_max_pooling #(
  parameter int IWIDTH = 35,
  parameter int OWIDTH = 17,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [IWIDTH-1:0] in_tensor [144],
  output logic                     busy,
  output logic                     done,
  output logic signed [OWIDTH-1:0] pool_res  [36]
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic signed [IWIDTH-1:0] SMAX =
    {{(IWIDTH-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [IWIDTH-1:0] SMIN =
    {{(IWIDTH-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

  state_t r_state;
  state_t w_state_nxt;

  logic [5:0] r_win;
  logic [1:0] r_ch;
  logic [1:0] r_pr;
  logic [1:0] r_pc;

  logic [7:0] w_base;
  logic signed [IWIDTH-1:0] w_a, w_b, w_c, w_d;
  logic signed [IWIDTH-1:0] w_m0, w_m1, w_m;
  logic signed [IWIDTH-1:0] w_s;
  logic signed [OWIDTH-1:0] w_res;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_win == 6'd35) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // window counter kept as ch/pr/pc digits to avoid dividers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win <= '0;
      r_ch  <= '0;
      r_pr  <= '0;
      r_pc  <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_win <= '0;
      r_ch  <= '0;
      r_pr  <= '0;
      r_pc  <= '0;
    end else if (r_state == S_RUN) begin
      r_win <= r_win + 6'd1;
      if (r_pc == 2'd2) begin
        r_pc <= '0;
        if (r_pr == 2'd2) begin
          r_pr <= '0;
          r_ch <= r_ch + 2'd1;
        end else begin
          r_pr <= r_pr + 2'd1;
        end
      end else begin
        r_pc <= r_pc + 2'd1;
      end
    end
  end

  // window fetch, max, shift and saturate
  always_comb begin
    w_base = 8'(r_ch) * 8'd36 + 8'(r_pr) * 8'd12 + 8'(r_pc) * 8'd2;
    w_a    = in_tensor[w_base];
    w_b    = in_tensor[w_base + 8'd1];
    w_c    = in_tensor[w_base + 8'd6];
    w_d    = in_tensor[w_base + 8'd7];
    w_m0   = (w_a > w_b) ? w_a : w_b;
    w_m1   = (w_c > w_d) ? w_c : w_d;
    w_m    = (w_m0 > w_m1) ? w_m0 : w_m1;
    w_s    = w_m >>> SHIFT;
    if (w_s > SMAX)      w_res = SMAX[OWIDTH-1:0];
    else if (w_s < SMIN) w_res = SMIN[OWIDTH-1:0];
    else                 w_res = w_s[OWIDTH-1:0];
  end

  // result array, one entry written per RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 36; i++) pool_res[i] <= '0;
    end else if (r_state == S_RUN) begin
      pool_res[r_win] <= w_res;
    end
  end

endmodule

// File: tb/tb_s3_max_pooling.sv
// tb_s3_max_pooling: scoreboard bench for s3_max_pooling,
// SHIFT=0 and SHIFT=2 instances share one input tensor.
module tb_s3_max_pooling;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic signed [34:0] tens [144];
  logic busy0, done0, busy2, done2;
  logic signed [16:0] pr0 [36];
  logic signed [16:0] pr2 [36];

  int total = 0;
  int bad = 0;

  longint q0[$];
  longint q2[$];

  always #5 clk = ~clk;

  s3_max_pooling #(.IWIDTH(35), .OWIDTH(17), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_tensor(tens),
    .busy(busy0), .done(done0), .pool_res(pr0)
  );

  s3_max_pooling #(.IWIDTH(35), .OWIDTH(17), .SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .in_tensor(tens),
    .busy(busy2), .done(done2), .pool_res(pr2)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_win(input int w, input int sh);
    int ch = w / 9;
    int pr = (w % 9) / 3;
    int pc = w % 3;
    longint m = -(64'sd1 <<< 40);
    longint s;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        longint v = longint'(tens[ch*36 + (2*pr+dr)*6 + 2*pc + dc]);
        if (v > m) m = v;
      end
    s = m >>> sh;
    if (s > 65535) s = 65535;
    if (s < -65536) s = -65536;
    return s;
  endfunction

  task automatic run(input bit hold);
    for (int w = 0; w < 36; w++) begin
      q0.push_back(ref_win(w, 0));
      q2.push_back(ref_win(w, 2));
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk("busy_e0", longint'(busy0), 1);
    for (int k = 0; k < 36; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("res0_%0d", k), longint'(pr0[k]), q0.pop_front());
      chk($sformatf("res2_%0d", k), longint'(pr2[k]), q2.pop_front());
      if (k < 35) begin
        chk("busy_run", longint'(busy0), 1);
        chk("done_run", longint'(done0), 0);
      end else begin
        chk("busy_end", longint'(busy0), 0);
        chk("done_end", longint'(done0), 1);
      end
    end
    @(posedge clk);
    #1;
    chk("done_drop", longint'(done0), 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("no_restart", longint'(busy0), 0);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 144; i++) tens[i] = 35'(i);
  endtask

  initial begin
    for (int i = 0; i < 144; i++) tens[i] = 35'($urandom);

    // reset held with start toggling
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = ~start;
    end
    #1;
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_done", longint'(done0), 0);
    for (int k = 0; k < 36; k++)
      chk("rst_res", longint'(pr0[k]), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", longint'(busy0), 0);
    chk("idle_res", longint'(pr0[0]), 0);

    // ramp
    set_ramp();
    run(1'b0);
    chk("ramp0", longint'(pr0[0]), 7);
    chk("ramp8", longint'(pr0[8]), 35);
    chk("ramp35", longint'(pr0[35]), 143);

    // max in each window-0 position
    for (int p = 0; p < 4; p++) begin
      int idx [4] = '{0, 1, 6, 7};
      tens[0] = 35'sd1; tens[1] = 35'sd1;
      tens[6] = 35'sd1; tens[7] = 35'sd1;
      tens[idx[p]] = 35'sd500;
      run(1'b0);
      chk("maxpos", longint'(pr0[0]), 500);
    end

    // mixed negatives
    tens[0] = -35'sd5; tens[1] = -35'sd3;
    tens[6] = -35'sd9; tens[7] = -35'sd1;
    run(1'b0);
    chk("neg", longint'(pr0[0]), -1);

    // saturation and shift
    for (int i = 0; i < 144; i++) tens[i] = 35'sd70000;
    run(1'b0);
    chk("sat0", longint'(pr0[20]), 65535);
    chk("shift2", longint'(pr2[20]), 17500);

    // large negative saturates low
    for (int i = 0; i < 144; i++) tens[i] = -35'sd1000000;
    run(1'b0);
    chk("satneg", longint'(pr0[3]), -65536);

    // start held through the whole run
    set_ramp();
    run(1'b1);

    // reset mid-run
    for (int i = 0; i < 144; i++) tens[i] = 35'(i * 3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_res9", longint'(pr0[9]), ref_win(9, 0));
    reset = 1'b0;
    #1;
    chk("mid_busy", longint'(busy0), 0);
    chk("mid_res0", longint'(pr0[0]), 0);
    chk("mid_res9z", longint'(pr0[9]), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_idle", longint'(busy0), 0);
    set_ramp();
    run(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
